shift_sequencer: RTL and testbench
==================================

Name: shift_sequencer

Overview:
- Sequences one shared `shifter` instance: load, N shift pulses, capture of the shifted result.
- Shares that shifter between two requesters (e.g. PIN-digit packer and balance-display formatter) using round-robin arbitration.
- Compensates for the shifter's one-shift output lag: `value` shows the register contents from before the most recent shift.
- Sits between the ATM control logic and the shifter.

Parameters:
- WIDTH, 5, data width; matches the shifter's 5-bit datapath.
- CNT_W, 3, width of each shift-amount field; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  2  per-requester job request; level, held until that requester's done.
- req_left  in  2  per-requester direction; 1 = left shift, 0 = right shift (logical, zero fill).
- req_amount  in  2*CNT_W  per-requester shift count; requester i uses bits [i*CNT_W +: CNT_W].
- req_value  in  2*WIDTH  per-requester operand; requester i uses bits [i*WIDTH +: WIDTH].
- grant  out  2  one-hot; marks the requester whose job is in flight.
- busy  out  1  high in every state except IDLE.
- done  out  2  one-cycle pulse to the granted requester when result is valid.
- result  out  WIDTH  shifted operand; held until the next capture.
- sh_load  out  1  drives shifter load.
- sh_right  out  1  drives shifter right.
- sh_left  out  1  drives shifter left.
- sh_in_value  out  WIDTH  drives shifter in_value.
- sh_value  in  WIDTH  shifter value output.

Behaviour:
- Reset (synchronous, rst high at a rising edge):
  - State goes to IDLE; the round-robin pointer goes to requester 0.
  - grant, done, busy, result, all sh_* outputs and the internal counter go to 0.
  - rst mid-job aborts the job: no done pulse, grant drops. The shifter's internal register is left as is; the next job reloads it.
- State machine: IDLE -> LOAD -> SHIFT -> CAPTURE -> DONE -> IDLE.
- IDLE:
  - If any req bit is high, pick a winner.
  - Only one requesting: that requester wins.
  - Both requesting: the requester the pointer names wins; the pointer then toggles to the other requester.
  - On the winning edge, latch the winner's direction, operand and clamped amount, set grant, go to LOAD.
- Clamping: an amount greater than WIDTH is treated as WIDTH.
- LOAD (1 cycle): sh_load=1, sh_in_value = latched operand, go to SHIFT. The counter is preset to amount+1.
- SHIFT (amount+1 cycles):
  - sh_left or sh_right = 1 per the latched direction; sh_load = 0.
  - The counter decrements each cycle; on the cycle it reads 1, go to CAPTURE.
  - The extra pulse is required: after k pulses, sh_value holds the register after k-1 shifts. Amount 0 therefore still issues exactly one pulse.
- CAPTURE (1 cycle): all sh_* strobes are 0; result <= sh_value; go to DONE.
- DONE (1 cycle):
  - done[granted] = 1 with result valid. grant stays set this cycle.
  - Next edge: grant clears, go to IDLE.
- Latency, from the first IDLE cycle with req high to done high: amount+4 cycles (IDLE, LOAD, amount+1 SHIFT cycles, CAPTURE), i.e. done is asserted in cycle amount+5.
- At most one of sh_load / sh_right / sh_left is high in any cycle. All three are low in IDLE, CAPTURE and DONE.
- Job inputs and req are sampled only in IDLE. Changing req_value, req_amount or req_left mid-job has no effect.
- Dropping req mid-job: the job completes and done still pulses.
- A requester still holding req after its done: re-arbitrated on the next IDLE cycle. The minimum gap between jobs is one IDLE cycle.
- Wrap-around: none; bits shifted out are lost. Amount of WIDTH or more gives result 0.

Test Plan:
- Reset, then req=01, req_left=0, amount=2, value=5'b10110 -> sh_load for 1 cycle, sh_right for 3 cycles, done[0] in cycle 7, result=5'b00101.
- req=10, req_left=1, amount=1, value=5'b10110 -> sh_left for 2 cycles, done[1] with result=5'b01100.
- Amount 0, value=5'b10011, right -> exactly one sh_right pulse, result=5'b10011.
- Amount 7, value=5'b11111, left -> clamped to 5, six sh_left pulses, result=5'b00000.
- req=11 held continuously, right, amount=1, value0=5'b00010, value1=5'b01000 -> done order 0,1,0,1; results alternate 5'b00001 and 5'b00100; one IDLE cycle between jobs.
- rst asserted during SHIFT -> next cycle all outputs 0, no done. A following req=01 job with value=5'b00001, left 1 -> result 5'b00010 (no stale shifter data).

Source files
------------

// File: rtl/shift_sequencer.sv
// shift_sequencer: round-robin sharing of one lagging shifter; load, amount+1 shift pulses, capture.
module shift_sequencer #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req,
  input  logic [1:0]           req_left,
  input  logic [2*CNT_W-1:0]   req_amount,
  input  logic [2*WIDTH-1:0]   req_value,
  output logic [1:0]           grant,
  output logic                 busy,
  output logic [1:0]           done,
  output logic [WIDTH-1:0]     result,
  output logic                 sh_load,
  output logic                 sh_right,
  output logic                 sh_left,
  output logic [WIDTH-1:0]     sh_in_value,
  input  logic [WIDTH-1:0]     sh_value
);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, CAPTURE, DONE} state_t;
  state_t state;
  logic ptr, dir_q, win;
  logic [CNT_W-1:0] amt_raw;
  logic [CNT_W:0] amt_c, amt_q, cnt;
  always_comb begin
    win = (req == 2'b11) ? ptr : req[1];
    amt_raw = win ? req_amount[CNT_W +: CNT_W] : req_amount[0 +: CNT_W];
    amt_c = ({1'b0, amt_raw} > (CNT_W+1)'(WIDTH)) ? (CNT_W+1)'(WIDTH) : {1'b0, amt_raw};
  end
  // the shifter's output lags one pulse, so SHIFT runs amount+1 cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 1'b0;
      dir_q <= 1'b0;
      amt_q <= '0;
      cnt <= '0;
      grant <= '0;
      busy <= 1'b0;
      done <= '0;
      result <= '0;
      sh_load <= 1'b0;
      sh_right <= 1'b0;
      sh_left <= 1'b0;
      sh_in_value <= '0;
    end else begin
      case (state)
        IDLE: if (|req) begin
          state <= LOAD;
          busy <= 1'b1;
          grant <= win ? 2'b10 : 2'b01;
          dir_q <= req_left[win];
          amt_q <= amt_c;
          sh_load <= 1'b1;
          sh_in_value <= win ? req_value[WIDTH +: WIDTH] : req_value[0 +: WIDTH];
          if (&req) ptr <= ~ptr;
        end
        LOAD: begin
          state <= SHIFT;
          sh_load <= 1'b0;
          sh_left <= dir_q;
          sh_right <= ~dir_q;
          cnt <= amt_q + 1'b1;
        end
        SHIFT: begin
          cnt <= cnt - 1'b1;
          if (cnt == (CNT_W+1)'(1)) begin
            state <= CAPTURE;
            sh_left <= 1'b0;
            sh_right <= 1'b0;
          end
        end
        CAPTURE: begin
          state <= DONE;
          result <= sh_value;
          done <= grant;
        end
        DONE: begin
          state <= IDLE;
          done <= '0;
          grant <= '0;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed jobs against a behavioural lagging shifter.
module tb_shift_sequencer;
  logic clk = 1'b0, rst = 1'b0;
  logic [1:0] req = '0, req_left = '0;
  logic [5:0] req_amount = '0;
  logic [9:0] req_value = '0;
  logic [1:0] grant, done;
  logic busy, sh_load, sh_right, sh_left;
  logic [4:0] result, sh_in_value, sh_value;
  logic [4:0] sh_reg = '0, sh_out = '0;
  int n_cmp = 0, n_bad = 0;

  shift_sequencer dut (
    .clk(clk), .rst(rst), .req(req), .req_left(req_left), .req_amount(req_amount),
    .req_value(req_value), .grant(grant), .busy(busy), .done(done), .result(result),
    .sh_load(sh_load), .sh_right(sh_right), .sh_left(sh_left),
    .sh_in_value(sh_in_value), .sh_value(sh_value)
  );

  always #5 clk = ~clk;

  // value output shows the register from before the latest operation
  always @(posedge clk) begin
    if (sh_load) begin sh_reg <= sh_in_value; sh_out <= sh_reg; end
    else if (sh_right) begin sh_reg <= sh_reg >> 1; sh_out <= sh_reg; end
    else if (sh_left) begin sh_reg <= sh_reg << 1; sh_out <= sh_reg; end
  end
  assign sh_value = sh_out;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_job(input logic [1:0] rq, input logic [1:0] lft, input logic [5:0] amt,
                         input logic [9:0] val, input int who, input int eff,
                         input logic [4:0] exp_res, input bit exp_left, input bit hold,
                         input string nm);
    int cyc, loads, pulses, wrong, multi;
    logic [1:0] oh;
    oh = (who == 1) ? 2'b10 : 2'b01;
    req = rq; req_left = lft; req_amount = amt; req_value = val;
    cyc = 1; loads = 0; pulses = 0; wrong = 0; multi = 0;
    while (done === 2'b00 && cyc < 40) begin
      tick;
      cyc++;
      if (!hold && cyc == 3) begin
        req = '0; req_left = ~lft; req_amount = ~amt; req_value = ~val;
      end
      loads += int'(sh_load);
      pulses += exp_left ? int'(sh_left) : int'(sh_right);
      wrong += exp_left ? int'(sh_right) : int'(sh_left);
      if (int'(sh_load) + int'(sh_left) + int'(sh_right) > 1) multi++;
    end
    n_cmp++; if (cyc !== eff + 5) begin n_bad++; $display("FAIL %s latency: got %0d want %0d", nm, cyc, eff + 5); end
    n_cmp++; if (done !== oh) begin n_bad++; $display("FAIL %s done: got %b want %b", nm, done, oh); end
    n_cmp++; if (grant !== oh) begin n_bad++; $display("FAIL %s grant: got %b want %b", nm, grant, oh); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL %s busy_at_done: got %b want 1", nm, busy); end
    n_cmp++; if (result !== exp_res) begin n_bad++; $display("FAIL %s result: got %b want %b", nm, result, exp_res); end
    n_cmp++; if (loads !== 1) begin n_bad++; $display("FAIL %s loads: got %0d want 1", nm, loads); end
    n_cmp++; if (pulses !== eff + 1) begin n_bad++; $display("FAIL %s pulses: got %0d want %0d", nm, pulses, eff + 1); end
    n_cmp++; if (wrong !== 0) begin n_bad++; $display("FAIL %s wrong_dir: got %0d want 0", nm, wrong); end
    n_cmp++; if (multi !== 0) begin n_bad++; $display("FAIL %s strobe_overlap: got %0d want 0", nm, multi); end
    if (!hold) req = '0;
    tick;
    n_cmp++; if ({done, grant, busy} !== 5'b0) begin n_bad++; $display("FAIL %s idle_after: got %b want 00000", nm, {done, grant, busy}); end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({grant, done, busy, result, sh_load, sh_right, sh_left, sh_in_value} !== 18'b0) begin
      n_bad++; $display("FAIL reset_state: got %b want 0", {grant, done, busy, result, sh_load, sh_right, sh_left, sh_in_value});
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_basic;
    run_job(2'b01, 2'b00, {3'd0, 3'd2}, {5'd0, 5'b10110}, 0, 2, 5'b00101, 1'b0, 1'b0, "right2");
    run_job(2'b10, 2'b10, {3'd1, 3'd0}, {5'b10110, 5'd0}, 1, 1, 5'b01100, 1'b1, 1'b0, "left1");
  endtask

  task automatic test_amount_zero;
    run_job(2'b01, 2'b00, {3'd0, 3'd0}, {5'd0, 5'b10011}, 0, 0, 5'b10011, 1'b0, 1'b0, "amount0");
  endtask

  task automatic test_clamp;
    run_job(2'b01, 2'b01, {3'd0, 3'd7}, {5'd0, 5'b11111}, 0, 5, 5'b00000, 1'b1, 1'b0, "clamp7");
  endtask

  task automatic test_back_to_back;
    for (int j = 0; j < 4; j++)
      run_job(2'b11, 2'b00, {3'd1, 3'd1}, {5'b01000, 5'b00010}, j % 2, 1,
              (j % 2) ? 5'b00100 : 5'b00001, 1'b0, j != 3, $sformatf("rr%0d", j));
    req = '0;
  endtask

  task automatic test_abort;
    int seen;
    req = 2'b01; req_left = 2'b00; req_amount = {3'd0, 3'd3}; req_value = {5'd0, 5'b10110};
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    req = '0;
    n_cmp++;
    if ({grant, done, busy, result, sh_load, sh_right, sh_left, sh_in_value} !== 18'b0) begin
      n_bad++; $display("FAIL abort_state: got %b want 0", {grant, done, busy, result, sh_load, sh_right, sh_left, sh_in_value});
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done !== 2'b00 || busy !== 1'b0) seen++;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_quiet: got %0d want 0", seen); end
    run_job(2'b01, 2'b01, {3'd0, 3'd1}, {5'd0, 5'b00001}, 0, 1, 5'b00010, 1'b1, 1'b0, "post_abort");
  endtask

  initial begin
    test_reset;
    test_basic;
    test_amount_zero;
    test_clamp;
    test_back_to_back;
    test_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
